ifu_fetch: RTL and testbench

//  Fetch control stage between the PC register and the decoder. Takes the current PC and issues
//  one read per instruction on the instruction-memory port. Buffers the returned word and offers
//  it downstream with a valid/ready handshake. Pulses o_ifu_wen to advance the PC register.

---
 rtl/ifu_fetch_pkg.sv | 30 +++
 rtl/ifu_fetch_if.sv | 29 ++
 rtl/ifu_fetch_buf.sv | 33 +++
 rtl/ifu_fetch.sv | 121 ++++++++++++
 tb/tb_ifu_fetch.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifu_fetch_pkg;

  localparam int unsigned CPU_WIDTH = 32;
  localparam int unsigned INST_W    = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef logic [1:0] ifu_err_t;

  localparam ifu_err_t IFU_ERR_OK  = 2'd0;
  localparam ifu_err_t IFU_ERR_MIS = 2'd1;
  localparam ifu_err_t IFU_ERR_BUS = 2'd2;
  localparam ifu_err_t IFU_ERR_TMO = 2'd3;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } ifu_state_e;

  // Entry held in the output register and offered to the decoder
  typedef struct packed {
    logic [INST_W-1:0]    inst;
    logic [CPU_WIDTH-1:0] pc;
    ifu_err_t             err;
  } ifu_inst_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory port and decoder handshake of the fetch stage.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic                 o_imem_req_valid;
  logic                 i_imem_req_ready;
  logic [CPU_WIDTH-1:0] o_imem_addr;
  logic                 i_imem_rsp_valid;
  logic [INST_W-1:0]    i_imem_rsp_data;
  logic                 i_imem_rsp_err;
  logic                 o_inst_valid;
  logic                 i_inst_ready;
  logic [INST_W-1:0]    o_inst;
  logic [CPU_WIDTH-1:0] o_inst_pc;
  ifu_err_t             o_inst_err;

  // Fetch stage side
  modport master (
    output o_imem_req_valid, o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_inst_err,
    input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_imem_rsp_err, i_inst_ready
  );

  // Memory and decoder side
  modport slave (
    input  o_imem_req_valid, o_imem_addr, o_inst_valid, o_inst, o_inst_pc, o_inst_err,
    output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_imem_rsp_err, i_inst_ready
  );

endinterface

// File: rtl/ifu_fetch_buf.sv
// Output holding register: one fetched entry plus its valid bit, with load and clear.
module ifu_fetch_buf
  import ifu_fetch_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_load,
  input  logic      i_clear,
  input  ifu_inst_t i_ent,
  output logic      o_valid,
  output ifu_inst_t o_ent
);

  logic      r_valid;
  ifu_inst_t r_ent;

  // Fields only change on load, so they stay stable while the decoder stalls
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_valid <= 1'b0;
      r_ent   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ent   <= i_ent;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_ent   = r_ent;

endmodule

// File: rtl/ifu_fetch.sv
// Fetch control: one imem read per PC, buffered handoff to the decoder, error and flush handling.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
)(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [CPU_WIDTH-1:0] i_ifu_pc,
  output logic                 o_ifu_wen,
  input  logic                 i_flush,
  ifu_fetch_if.master          bus
);

  localparam logic             TMO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic                 r_armed;
  ifu_state_e           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_pending;
  logic [CPU_WIDTH-1:0] r_req_pc;

  logic      w_misal, w_flush, w_in_req, w_mis_ld, w_accept;
  logic      w_wait, w_rsp_ld, w_tmo, w_fire, w_load, w_clear;
  logic      w_pend_n, w_vld_n, w_buf_valid;
  ifu_inst_t w_ld, w_buf;

  // r_armed keeps the request and PC strobe quiet until the first edge out of reset
  assign w_misal  = |i_ifu_pc[1:0];
  assign w_flush  = r_armed & i_flush;
  assign w_in_req = r_armed & ~i_flush & (r_state == ST_REQ);
  assign w_mis_ld = w_in_req & w_misal;
  assign w_accept = bus.o_imem_req_valid & bus.i_imem_req_ready;
  assign w_wait   = ~i_flush & (r_state == ST_WAIT);
  assign w_rsp_ld = w_wait & bus.i_imem_rsp_valid;
  assign w_tmo    = TMO_EN & w_wait & ~bus.i_imem_rsp_valid & (r_cnt == TMO_LAST);
  assign w_fire   = w_buf_valid & bus.i_inst_ready & ~i_flush;
  assign w_load   = w_mis_ld | w_rsp_ld | w_tmo;
  assign w_clear  = w_fire | w_flush;
  assign w_pend_n = r_pending & ~bus.i_imem_rsp_valid;
  assign w_vld_n  = w_buf_valid & ~w_clear;

  // PC strobe is same-cycle so the PC register advances on the edge that leaves HOLD
  assign o_ifu_wen            = w_flush | w_fire;
  assign bus.o_imem_req_valid = w_in_req & ~w_misal;
  assign bus.o_imem_addr      = {i_ifu_pc[CPU_WIDTH-1:2], 2'b00};

  always_comb begin
    w_ld = '{inst: bus.i_imem_rsp_data, pc: r_req_pc, err: IFU_ERR_OK};
    if (w_mis_ld) begin
      w_ld = '{inst: NOP_INST, pc: i_ifu_pc, err: IFU_ERR_MIS};
    end else if (w_tmo) begin
      w_ld = '{inst: NOP_INST, pc: r_req_pc, err: IFU_ERR_TMO};
    end else if (bus.i_imem_rsp_err) begin
      w_ld = '{inst: NOP_INST, pc: r_req_pc, err: IFU_ERR_BUS};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_armed   <= 1'b0;
      r_state   <= ST_REQ;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_req_pc  <= '0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        ST_REQ: begin
          if (w_mis_ld) begin
            r_state <= ST_HOLD;
          end else if (w_accept) begin
            r_state  <= ST_WAIT;
            r_cnt    <= '0;
            r_req_pc <= i_ifu_pc;
          end
        end
        ST_WAIT: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
          if (i_flush) begin
            r_pending <= ~bus.i_imem_rsp_valid;
            r_state   <= bus.i_imem_rsp_valid ? ST_REQ : ST_DRAIN;
          end else if (w_rsp_ld) begin
            r_state <= ST_HOLD;
          end else if (w_tmo) begin
            r_pending <= 1'b1;
            r_state   <= ST_DRAIN;
          end
        end
        ST_HOLD: begin
          if (w_clear) r_state <= ST_REQ;
        end
        ST_DRAIN: begin
          // Leave only once the stale response is gone and any timeout entry was taken
          r_pending <= w_pend_n;
          if (!i_flush && !w_pend_n && !w_vld_n) r_state <= ST_REQ;
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

  ifu_fetch_buf u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_ent   (w_ld),
    .o_valid (w_buf_valid),
    .o_ent   (w_buf)
  );

  assign bus.o_inst_valid = w_buf_valid;
  assign bus.o_inst       = w_buf.inst;
  assign bus.o_inst_pc    = w_buf.pc;
  assign bus.o_inst_err   = w_buf.err;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: scripted memory/PC model, scoreboard of expected deliveries.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic                 ifu_wen;
  logic [CPU_WIDTH-1:0] pc;
  logic [CPU_WIDTH-1:0] redir_pc;
  logic                 rsp_err_mode;
  logic [31:0]          pend_addr;

  int n_cmp = 0;
  int n_err = 0;
  int wen_cnt = 0;
  int req_cnt = 0;
  int cd = 0;
  int rsp_delay = 1;
  int wb;

  ifu_inst_t exp_q[$];

  ifu_fetch_if bus ();

  ifu_fetch #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .i_clk     (clk),
    .i_rst     (rst_n),
    .i_ifu_pc  (pc),
    .o_ifu_wen (ifu_wen),
    .i_flush   (flush),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[19:0], 12'h000};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p, input logic [1:0] e);
    ifu_inst_t t;
    t.inst = i;
    t.pc   = p;
    t.err  = e;
    exp_q.push_back(t);
  endtask

  // One clock: sample at negedge, then update PC register and memory model after posedge
  task automatic tick();
    logic acc, wen, fl;
    logic [31:0] a;
    @(negedge clk);
    acc = bus.o_imem_req_valid & bus.i_imem_req_ready;
    a   = bus.o_imem_addr;
    wen = ifu_wen;
    fl  = flush;
    @(posedge clk);
    #1;
    if (wen) pc = fl ? redir_pc : pc + 32'd4;
    bus.i_imem_rsp_valid = 1'b0;
    if (!rst_n) begin
      cd = 0;
    end else begin
      if (acc) begin
        cd        = rsp_delay;
        pend_addr = a;
        req_cnt++;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.i_imem_rsp_valid = 1'b1;
          bus.i_imem_rsp_data  = mem_word(pend_addr);
          bus.i_imem_rsp_err   = rsp_err_mode;
        end
      end
    end
    #1;
  endtask

  // Scoreboard monitor: every delivered instruction must match the head of the queue
  initial begin
    ifu_inst_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ifu_wen) wen_cnt++;
        if (bus.o_inst_valid && bus.i_inst_ready && !flush) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL deliver_unexpected: got inst=%h pc=%h err=%0d required none",
                     bus.o_inst, bus.o_inst_pc, bus.o_inst_err);
          end else begin
            e = exp_q.pop_front();
            if (bus.o_inst !== e.inst || bus.o_inst_pc !== e.pc || bus.o_inst_err !== e.err) begin
              n_err++;
              $display("FAIL deliver: got inst=%h pc=%h err=%0d required inst=%h pc=%h err=%0d",
                       bus.o_inst, bus.o_inst_pc, bus.o_inst_err, e.inst, e.pc, e.err);
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    pc = 32'h8000_0000;
    redir_pc = '0;
    rsp_err_mode = 1'b0;
    pend_addr = '0;
    bus.i_imem_req_ready = 1'b0;
    bus.i_inst_ready = 1'b1;
    bus.i_imem_rsp_valid = 1'b0;
    bus.i_imem_rsp_data = '0;
    bus.i_imem_rsp_err = 1'b0;
    repeat (3) tick();
    chk("rst_req_valid", 64'(bus.o_imem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(bus.o_inst_valid), 64'd0);
    chk("rst_wen", 64'(ifu_wen), 64'd0);
    chk("rst_inst", 64'(bus.o_inst), 64'd0);
    chk("rst_inst_pc", 64'(bus.o_inst_pc), 64'd0);
    chk("rst_inst_err", 64'(bus.o_inst_err), 64'd0);

    // 1: first fetch after reset release, valid on the third cycle
    rst_n = 1'b1;
    bus.i_imem_req_ready = 1'b1;
    push(32'h0050_0093, 32'h8000_0000, IFU_ERR_OK);
    tick();
    chk("t1_req_valid", 64'(bus.o_imem_req_valid), 64'd1);
    chk("t1_addr", 64'(bus.o_imem_addr), 64'h8000_0000);
    tick();
    chk("t1_valid_c2", 64'(bus.o_inst_valid), 64'd0);
    bus.i_imem_req_ready = 1'b0;
    tick();
    chk("t1_valid_c3", 64'(bus.o_inst_valid), 64'd1);
    chk("t1_wen_fire", 64'(ifu_wen), 64'd1);
    tick();
    chk("t1_wen_cnt", 64'(wen_cnt), 64'd1);
    chk("t1_wen_low", 64'(ifu_wen), 64'd0);
    chk("t1_req_hold", 64'(bus.o_imem_req_valid), 64'd1);
    chk("t1_next_addr", 64'(bus.o_imem_addr), 64'h8000_0004);

    // 2: decoder stalls five cycles
    bus.i_imem_req_ready = 1'b1;
    bus.i_inst_ready = 1'b0;
    push(32'h0050_4093, 32'h8000_0004, IFU_ERR_OK);
    tick();
    bus.i_imem_req_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_valid", 64'(bus.o_inst_valid), 64'd1);
      chk("t2_stall_word", {bus.o_inst, bus.o_inst_pc}, {32'h0050_4093, 32'h8000_0004});
      chk("t2_stall_quiet", {62'd0, ifu_wen, bus.o_imem_req_valid}, 64'd0);
      tick();
    end
    chk("t2_req_cnt", 64'(req_cnt), 64'd2);
    bus.i_inst_ready = 1'b1;
    tick();
    chk("t2_wen_cnt", 64'(wen_cnt), 64'd2);

    // 3: misaligned PC, no memory request
    pc = 32'h8000_0002;
    bus.i_inst_ready = 1'b0;
    push(NOP_INST, 32'h8000_0002, IFU_ERR_MIS);
    #1;
    chk("t3_no_req", 64'(bus.o_imem_req_valid), 64'd0);
    tick();
    chk("t3_valid", 64'(bus.o_inst_valid), 64'd1);
    chk("t3_err", 64'(bus.o_inst_err), 64'd1);
    chk("t3_inst", 64'(bus.o_inst), 64'h13);
    chk("t3_pc", 64'(bus.o_inst_pc), 64'h8000_0002);
    bus.i_inst_ready = 1'b1;
    tick();
    pc = 32'h8000_0008;
    chk("t3_req_cnt", 64'(req_cnt), 64'd2);

    // 4a: bus error response
    rsp_err_mode = 1'b1;
    bus.i_imem_req_ready = 1'b1;
    push(NOP_INST, 32'h8000_0008, IFU_ERR_BUS);
    tick();
    bus.i_imem_req_ready = 1'b0;
    rsp_err_mode = 1'b0;
    tick();
    chk("t4_bus_err", 64'(bus.o_inst_err), 64'd2);
    tick();
    chk("t4_q_empty", 64'(exp_q.size()), 64'd0);

    // 4b: timeout after four WAIT cycles, late response dropped
    rsp_delay = 6;
    bus.i_imem_req_ready = 1'b1;
    bus.i_inst_ready = 1'b0;
    push(NOP_INST, 32'h8000_000C, IFU_ERR_TMO);
    tick();
    bus.i_imem_req_ready = 1'b0;
    repeat (3) tick();
    chk("t4_tmo_early", 64'(bus.o_inst_valid), 64'd0);
    tick();
    chk("t4_tmo_valid", 64'(bus.o_inst_valid), 64'd1);
    chk("t4_tmo_err", 64'(bus.o_inst_err), 64'd3);
    chk("t4_tmo_pc", 64'(bus.o_inst_pc), 64'h8000_000C);
    tick();
    tick();
    chk("t4_drain_hold", 64'(bus.o_inst_valid), 64'd1);
    chk("t4_drain_noreq", 64'(bus.o_imem_req_valid), 64'd0);
    bus.i_inst_ready = 1'b1;
    rsp_delay = 3;
    tick();
    chk("t4_next_req", 64'(bus.o_imem_req_valid), 64'd1);
    chk("t4_next_addr", 64'(bus.o_imem_addr), 64'h8000_0010);
    chk("t4_wen_cnt", 64'(wen_cnt), 64'd5);

    // 5: flush in WAIT, response two cycles later is discarded
    redir_pc = 32'h8000_0100;
    bus.i_imem_req_ready = 1'b1;
    tick();
    bus.i_imem_req_ready = 1'b0;
    flush = 1'b1;
    wb = wen_cnt;
    #1;
    chk("t5_wen_flush", 64'(ifu_wen), 64'd1);
    tick();
    flush = 1'b0;
    chk("t5_no_valid_a", 64'(bus.o_inst_valid), 64'd0);
    tick();
    chk("t5_no_valid_b", 64'(bus.o_inst_valid), 64'd0);
    tick();
    chk("t5_wen_once", 64'(wen_cnt), 64'(wb + 1));
    chk("t5_redirect", 64'(bus.o_imem_addr), 64'h8000_0100);
    chk("t5_req_valid", 64'(bus.o_imem_req_valid), 64'd1);

    // 6a: flush coincides with fire in HOLD
    rsp_delay = 1;
    bus.i_imem_req_ready = 1'b1;
    bus.i_inst_ready = 1'b0;
    tick();
    bus.i_imem_req_ready = 1'b0;
    tick();
    chk("t6_hold_inst", 64'(bus.o_inst), 64'h0040_0093);
    bus.i_inst_ready = 1'b1;
    flush = 1'b1;
    redir_pc = 32'h8000_0200;
    wb = wen_cnt;
    tick();
    flush = 1'b0;
    chk("t6_wen_once", 64'(wen_cnt), 64'(wb + 1));
    chk("t6_valid_off", 64'(bus.o_inst_valid), 64'd0);
    chk("t6_pc", 64'(pc), 64'h8000_0200);

    // 6b: async reset mid-WAIT clears outputs at once
    rsp_delay = 5;
    bus.i_imem_req_ready = 1'b1;
    tick();
    bus.i_imem_req_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 64'(bus.o_imem_req_valid), 64'd0);
    chk("t6_rst_valid", 64'(bus.o_inst_valid), 64'd0);
    chk("t6_rst_wen", 64'(ifu_wen), 64'd0);
    chk("t6_rst_fields", {bus.o_inst, bus.o_inst_pc}, 64'd0);
    chk("t6_rst_err", 64'(bus.o_inst_err), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    rsp_delay = 1;
    bus.i_imem_req_ready = 1'b1;
    push(32'h0070_0093, 32'h8000_0200, IFU_ERR_OK);
    tick();
    tick();
    bus.i_imem_req_ready = 1'b0;
    repeat (3) tick();
    chk("end_q_empty", 64'(exp_q.size()), 64'd0);
    chk("end_pc", 64'(pc), 64'h8000_0204);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
